// File: rtl/ssd_display_driver_pkg.sv
// Shared constants for the seven-segment driver: active-low segment patterns,
// conversion FSM encodings and the digit-to-segment decoder.
package ssd_display_driver_pkg;

    // Segment order {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Non-decimal nibbles show as blank rather than garbage
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_display_driver_bin_to_bcd_seq.sv
// Sequential double-dabble converter: load, one bit per cycle for WIDTH cycles,
// then a single DONE cycle during which bcd holds the finished result.
module bin_to_bcd_seq
    import ssd_display_driver_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]          state;
    logic [WIDTH-1:0]    shift_reg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       bit_cnt;

    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shift_reg <= bin;
                        scratch   <= '0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {scratch, shift_reg} <= {adj, shift_reg} << 1;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == CW'(WIDTH - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign done = (state == S_DONE);
    assign bcd  = scratch;

endmodule

// File: rtl/ssd_display_driver.sv
// 4-digit common-anode display driver: detects changes on value, converts to
// BCD in the background and scans the last completed result across the digits.
module ssd_display_driver
    import ssd_display_driver_pkg::*;
#(
    parameter int WIDTH        = 13,
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 18,
    parameter int BLANK_ZEROS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out
);

    logic [WIDTH-1:0]           last_value;
    logic [WIDTH-1:0]           cap_value;
    logic                       conv_busy;
    logic                       conv_done;
    logic                       start;
    logic [4*DIGITS-1:0]        conv_bcd;
    logic [REFRESH_BITS-1:0]    refresh_cnt;
    logic [1:0]                 dsel;
    logic [DIGITS-1:0]          digit_blank;
    logic [DIGITS-1:0][6:0]     digit_seg;

    // Changes arriving mid-conversion are picked up once the engine is idle again
    assign start = !conv_busy && (value != last_value);

    bin_to_bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_value <= '0;
            cap_value  <= '0;
            bcd_out    <= '0;
        end else begin
            if (start)
                cap_value <= value;
            if (conv_done) begin
                bcd_out    <= conv_bcd;
                last_value <= cap_value;
            end
        end
    end

    assign busy = conv_busy;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_lsd
            assign digit_blank[k] = 1'b0;
        end else begin : g_upper
            assign digit_blank[k] = (BLANK_ZEROS != 0) && (bcd_out[4*DIGITS-1:4*k] == '0);
        end
        assign digit_seg[k] = digit_blank[k] ? SEG_BLANK : seg_encode(bcd_out[4*k +: 4]);
    end

    assign dsel = refresh_cnt[REFRESH_BITS-1 -: 2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            an          <= '1;
            seg         <= SEG_BLANK;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
            an          <= ~(DIGITS'(1) << dsel);
            seg         <= digit_seg[dsel];
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Bench for ssd_display_driver: decimal-arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ssd_display_driver;

    localparam int RB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] value = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic [15:0] bcd_out;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    ssd_display_driver #(
        .WIDTH        (13),
        .DIGITS       (4),
        .REFRESH_BITS (RB),
        .BLANK_ZEROS  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .busy    (busy),
        .bcd_out (bcd_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Reference model: a conversion is a 15-edge timer started by a change
    logic [3:0]  m_an   = 4'hF;
    logic [6:0]  m_seg  = 7'h7F;
    logic        m_busy = 1'b0;
    logic [15:0] m_bcd  = '0;
    logic [12:0] m_last = '0;
    logic [12:0] m_cap  = '0;
    int          m_cnt  = 0;
    int          m_timer = 0;
    int          m_d;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_an = 4'hF; m_seg = 7'h7F; m_busy = 1'b0; m_bcd = '0;
            m_last = '0; m_cap = '0; m_cnt = 0; m_timer = 0;
        end else begin
            m_d   = (m_cnt / (1 << (RB - 2))) % 4;
            m_an  = ~(4'b0001 << m_d);
            m_seg = (m_d > 0 && (m_bcd >> (4 * m_d)) == 16'h0) ? 7'h7F : enc(m_bcd[4*m_d +: 4]);
            m_cnt = (m_cnt + 1) % (1 << RB);
            if (m_timer == 0) begin
                if (value !== m_last) begin
                    m_cap = value; m_timer = 14; m_busy = 1'b1;
                end
            end else begin
                m_timer--;
                if (m_timer == 0) begin
                    m_bcd = to_bcd(int'(m_cap)); m_last = m_cap; m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_an", an, m_an);
        check("model_seg", seg, m_seg);
        check("model_dp", dp, 1'b1);
        check("model_busy", busy, m_busy);
        check("model_bcd", bcd_out, m_bcd);
    end

    // Waits for bcd_out == exp counting edges from the next (detection) edge
    task automatic convert_wait(input string name, input logic [15:0] exp, input int exp_lat,
                                input int chg_at, input logic [12:0] chg_val);
        int n;
        for (n = 1; n <= 60; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 1) check({name, "_busy_rise"}, busy, 1'b1);
            if (n == chg_at) value = chg_val;
            if (bcd_out == exp) break;
        end
        if (exp_lat > 0) check({name, "_latency"}, n, exp_lat);
        check({name, "_bcd"}, bcd_out, exp);
    endtask

    task automatic scan(input string name, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: check({name, "_d0"}, seg, s0);
                4'b1101: check({name, "_d1"}, seg, s1);
                4'b1011: check({name, "_d2"}, seg, s2);
                4'b0111: check({name, "_d3"}, seg, s3);
                default: check({name, "_an"}, an, 4'b1110);
            endcase
        end
    endtask

    initial begin
        logic [3:0] prev;
        int run, changes;
        // 1: reset and idle display of zero
        rst = 1'b0; value = '0;
        repeat (3) begin
            @(negedge clk);
            check("rst_an", an, 4'b1111);
            check("rst_seg", seg, 7'b1111111);
            check("rst_bcd", bcd_out, 16'h0000);
        end
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
        end
        scan("zero", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);

        // 2: 1234
        value = 13'd1234;
        convert_wait("v1234", 16'h1234, 15, 0, '0);
        scan("s1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

        // 3: max value, then back to zero
        value = 13'd8191;
        convert_wait("v8191", 16'h8191, 15, 0, '0);
        value = 13'd0;
        convert_wait("v0", 16'h0000, 15, 0, '0);
        scan("s0", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);

        // 4: change while busy is deferred
        value = 13'd1234;
        convert_wait("late_first", 16'h1234, 15, 5, 13'd42);
        convert_wait("late_second", 16'h0042, 15, 0, '0);
        scan("s42", 7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111);

        // 5: reset mid-conversion
        value = 13'd999;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_bcd", bcd_out, 16'h0000);
        check("midrst_an", an, 4'b1111);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        convert_wait("v999", 16'h0999, 15, 0, '0);

        // 6: free-running scan order and hold time
        @(negedge clk);
        prev = an; run = 1; changes = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check("scan_onehot", $countones(~an), 1);
            check("scan_dp", dp, 1'b1);
            if (an != prev) begin
                check("scan_rot", an, {prev[2:0], prev[3]});
                if (changes > 0) check("scan_hold", run, 4);
                changes++; run = 1; prev = an;
            end else begin
                run++;
            end
        end
        check("scan_changes", changes >= 15, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
